tube_scan_driver: RTL and testbench
===================================

TUBE_SCAN_DRIVER -- requirements
Module: tube_scan_driver

Interface
REQ-001 The block SHALL have parameter SCAN_DIV, default 50000, giving clk cycles per scan position (minimum 2).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port wr_en, input, 1 bit: one-cycle strobe to load a new display value.
REQ-005 The block SHALL have port wr_data, input, 32 bits: value to display, sampled when wr_en=1.
REQ-006 The block SHALL have port dec_mode, input, 1 bit: sampled with wr_en; 0 = hex, 1 = unsigned decimal.
REQ-007 The block SHALL have port busy, output, 1 bit: decimal conversion in progress.
REQ-008 The block SHALL have port tubSel, output, 8 bits: digit enables, active-high; bit k drives digit k, where digit 7 is leftmost.
REQ-009 The block SHALL have port tubLeft, output, 8 bits: segments for digits 7..4, encoded {dp,g,f,e,d,c,b,a}, active-high.
REQ-010 The block SHALL have port tubRight, output, 8 bits: segments for digits 3..0, encoded the same way as tubLeft.

Function
REQ-011 The block SHALL hold eight 5-bit display codes, one per digit: 0-F glyph, BLANK (segments 8'h00), or E (8'h79); dp SHALL always be 0.
REQ-012 Glyph encoding SHALL be the standard set: 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71.
REQ-013 Scan counter SHALL count 0..SCAN_DIV-1 and wrap to 0; on wrap, 2-bit index i SHALL increment mod 4.
REQ-014 Outputs SHALL be registered: one cycle after index becomes i, tubSel = (1<<(i+4)) | (1<<i), tubLeft = glyph(digit i+4), tubRight = glyph(digit i).
REQ-015 Hex write (wr_en=1, dec_mode=0): the next cycle, digit k SHALL hold wr_data[4k+3:4k]; no blanking; busy SHALL stay 0.
REQ-016 A hex write SHALL abort any conversion in progress: busy = 0 the next cycle, and the partial result SHALL be discarded.
REQ-017 Decimal write with wr_data > 99_999_999: the next cycle, digit 0 SHALL hold E and digits 7..1 SHALL hold BLANK; busy SHALL stay 0; any running conversion SHALL be aborted.
REQ-018 Decimal write with wr_data <= 99_999_999: FSM SHALL go IDLE -> CONV; busy = 1 from the next cycle for exactly 27 cycles.
REQ-019 In CONV, the block SHALL shift-add-3 (double dabble) on wr_data[26:0], MSB first, one bit per cycle.
REQ-020 Digits SHALL keep their old value throughout CONV.
REQ-021 In the 27th CONV cycle, the block SHALL commit the BCD digits to the display and return to IDLE; busy = 0 the following cycle.
REQ-022 Decimal commit SHALL blank leading zero digits 7..1; digit 0 SHALL always be shown.
REQ-023 Decimal write while busy SHALL restart the conversion with the new value; the 27-cycle count SHALL restart from the next cycle. Last write wins.
REQ-024 wr_en SHALL be ignored in the same cycle as rst=1.
REQ-025 Scanning SHALL run continuously and SHALL be unaffected by writes or conversion.

Reset
REQ-026 With rst=1 at a clock edge: scan counter = 0, index = 0, FSM = IDLE, busy = 0, all digits = glyph 0.
REQ-027 The cycle after reset: tubSel = 8'h11, tubLeft = 8'h3F, tubRight = 8'h3F.
REQ-028 Reset mid-conversion SHALL abandon the conversion; the display SHALL show all zeros, not the partial result.

Verification
REQ-029 Scan: SCAN_DIV=4, no writes after reset -> tubSel steps 11,22,44,88,11 every 4 cycles; both segment buses = 3F throughout.
REQ-030 Hex: write 32'h1234ABCD, dec_mode=0 -> at index 0: tubLeft=66 (4), tubRight=5E (d); at index 3: tubLeft=06 (1), tubRight=77 (A); busy never 1.
REQ-031 Decimal: write 305, dec_mode=1 -> busy high 27 cycles, display unchanged meanwhile; then digits 3,0,5, digits 7..3 BLANK (00), digit 2 = 4F.
REQ-032 Overflow: write 100_000_000, dec_mode=1 -> next cycle digit 0 = 79, all other digits 00, busy 0.
REQ-033 Restart/abort: write 99_999_999 decimal, at cycle 10 write 7 decimal -> busy stays 1 until 27 cycles after the second write, result 7 with 7 blanks; repeat with a hex write at cycle 10 -> busy drops next cycle, hex value shown.
REQ-034 Reset mid-conversion: decimal write, rst at cycle 5 -> busy 0, tubSel=11, segments 3F the next cycle.

Source files
------------

// File: rtl/tube_scan_driver.sv
// tube_scan_driver: eight-digit seven-segment scan driver.
// Holds one 5-bit code per digit and shows them in hex or in unsigned decimal.
// Two digits are lit at a time: digit i on the right bus and digit i+4 on the left bus.
// Decimal values go through a serial double-dabble conversion, one bit per clock.
// Handshake: wr_en is a single-cycle strobe with no ready.
//   wr_data and dec_mode are sampled only on cycles with wr_en=1.
//   Every write is accepted, and the last write wins.
//   busy is status only and never stalls a write.
module tube_scan_driver #(
  parameter int SCAN_DIV = 50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic [31:0] wr_data,
  input  logic        dec_mode,
  output logic        busy,
  output logic [7:0]  tubSel,
  output logic [7:0]  tubLeft,
  output logic [7:0]  tubRight
);

  localparam int CW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] SCAN_LAST = CW'(SCAN_DIV - 1);
  localparam logic [4:0] C_BLANK = 5'd16;
  localparam logic [4:0] C_ERR   = 5'd17;
  localparam logic [31:0] DEC_MAX = 32'd99_999_999;

  typedef enum logic {S_IDLE, S_CONV} state_t;

  logic [CW-1:0] r_scan_cnt;
  logic [1:0]    r_idx;
  logic [4:0]    r_dig [8];
  state_t        r_state;
  logic [26:0]   r_bin;
  logic [31:0]   r_bcd;
  logic [4:0]    r_step;

  logic [31:0]   w_adj;
  logic [31:0]   w_shift;
  logic [4:0]    w_dec_code [8];
  logic [7:0]    w_lead_nz;
  logic          w_overflow;

  // Maps a digit code to its segment pattern; dp is never lit.
  function automatic logic [7:0] f_glyph(input logic [4:0] c);
    logic [7:0] g;
    case (c)
      5'd0:    g = 8'h3F;
      5'd1:    g = 8'h06;
      5'd2:    g = 8'h5B;
      5'd3:    g = 8'h4F;
      5'd4:    g = 8'h66;
      5'd5:    g = 8'h6D;
      5'd6:    g = 8'h7D;
      5'd7:    g = 8'h07;
      5'd8:    g = 8'h7F;
      5'd9:    g = 8'h6F;
      5'd10:   g = 8'h77;
      5'd11:   g = 8'h7C;
      5'd12:   g = 8'h39;
      5'd13:   g = 8'h5E;
      5'd14:   g = 8'h79;
      5'd15:   g = 8'h71;
      C_ERR:   g = 8'h79;
      default: g = 8'h00;
    endcase
    return g;
  endfunction

  assign w_overflow = (wr_data > DEC_MAX);

  // One double-dabble step: add 3 to every BCD nibble >= 5, then shift in the next binary bit.
  // Also builds the display codes for the commit: leading zeros on digits 7..1 are blanked.
  always_comb begin
    w_adj     = '0;
    w_lead_nz = '0;
    for (int k = 0; k < 8; k++) begin
      w_adj[4*k +: 4] = (r_bcd[4*k +: 4] >= 4'd5) ? r_bcd[4*k +: 4] + 4'd3 : r_bcd[4*k +: 4];
    end
    w_shift = {w_adj[30:0], r_bin[26]};
    // w_lead_nz[k] is set when digit k or any digit to its left is nonzero.
    w_lead_nz[7] = (w_shift[31:28] != 4'd0);
    for (int k = 6; k >= 0; k--) begin
      w_lead_nz[k] = w_lead_nz[k+1] | (w_shift[4*k +: 4] != 4'd0);
    end
    for (int k = 0; k < 8; k++) begin
      w_dec_code[k] = (w_lead_nz[k] || k == 0) ? {1'b0, w_shift[4*k +: 4]} : C_BLANK;
    end
  end

  // Free-running scan position: the divider counter, and the digit-pair index that steps on each wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_scan_cnt <= '0;
      r_idx      <= 2'd0;
    end else if (r_scan_cnt == SCAN_LAST) begin
      r_scan_cnt <= '0;
      r_idx      <= r_idx + 2'd1;
    end else begin
      r_scan_cnt <= r_scan_cnt + CW'(1);
    end
  end

  // Registered outputs: the digit-pair enables and the glyphs for the current index.
  always_ff @(posedge clk) begin
    if (rst) begin
      tubSel   <= 8'h11;
      tubLeft  <= 8'h3F;
      tubRight <= 8'h3F;
    end else begin
      tubSel   <= (8'h10 << r_idx) | (8'h01 << r_idx);
      tubLeft  <= f_glyph(r_dig[{1'b1, r_idx}]);
      tubRight <= f_glyph(r_dig[{1'b0, r_idx}]);
    end
  end

  // Write handling and the conversion FSM.
  // A hex write or an out-of-range decimal write aborts any running conversion.
  // A decimal write restarts the conversion.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      busy    <= 1'b0;
      r_bin   <= '0;
      r_bcd   <= '0;
      r_step  <= '0;
      for (int k = 0; k < 8; k++) r_dig[k] <= 5'd0;
    end else if (wr_en) begin
      if (!dec_mode) begin
        r_state <= S_IDLE;
        busy    <= 1'b0;
        for (int k = 0; k < 8; k++) r_dig[k] <= {1'b0, wr_data[4*k +: 4]};
      end else if (w_overflow) begin
        r_state <= S_IDLE;
        busy    <= 1'b0;
        r_dig[0] <= C_ERR;
        for (int k = 1; k < 8; k++) r_dig[k] <= C_BLANK;
      end else begin
        r_state <= S_CONV;
        busy    <= 1'b1;
        r_bin   <= wr_data[26:0];
        r_bcd   <= '0;
        r_step  <= '0;
      end
    end else begin
      case (r_state)
        S_CONV: begin
          r_bcd  <= w_shift;
          r_bin  <= {r_bin[25:0], 1'b0};
          r_step <= r_step + 5'd1;
          if (r_step == 5'd26) begin
            r_state <= S_IDLE;
            busy    <= 1'b0;
            for (int k = 0; k < 8; k++) r_dig[k] <= w_dec_code[k];
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tube_scan_driver.sv
// tb_tube_scan_driver: drives directed and random writes into tube_scan_driver.
// A behavioural model predicts every output on every cycle.
// Decimal results come from /10 and %10 arithmetic, and conversion timing from a countdown.
module tb_tube_scan_driver;

  localparam int SCAN_DIV = 4;

  logic        clk;
  logic        rst;
  logic        wr_en;
  logic [31:0] wr_data;
  logic        dec_mode;
  logic        busy;
  logic [7:0]  tubSel;
  logic [7:0]  tubLeft;
  logic [7:0]  tubRight;

  int n_tests;
  int n_fail;

  // Model state
  logic [7:0] m_seg [8];
  int         m_pos;
  int         m_remaining;
  logic [31:0] m_pending;
  logic       m_busy;
  logic [7:0] glyph_tab [16];

  tube_scan_driver #(.SCAN_DIV(SCAN_DIV)) dut (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .dec_mode (dec_mode),
    .busy     (busy),
    .tubSel   (tubSel),
    .tubLeft  (tubLeft),
    .tubRight (tubRight)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Fills the model display from a decimal value.
  // Leading zeros are blanked, and digit 0 is always shown.
  task automatic model_commit_dec(input logic [31:0] v);
    longint p;
    p = 1;
    for (int k = 0; k < 8; k++) begin
      if (k > 0 && longint'(v) < p) m_seg[k] = 8'h00;
      else m_seg[k] = glyph_tab[(longint'(v) / p) % 10];
      p = p * 10;
    end
  endtask

  // One clock: drive inputs, advance the model at the edge, then check the outputs.
  task automatic step(input logic s_rst, input logic s_wr, input logic [31:0] s_data, input logic s_dec);
    logic [7:0] e_sel, e_left, e_right;
    int idx;
    @(negedge clk);
    rst = s_rst; wr_en = s_wr; wr_data = s_data; dec_mode = s_dec;
    @(posedge clk);
    if (s_rst) begin
      e_sel = 8'h11; e_left = 8'h3F; e_right = 8'h3F;
      for (int k = 0; k < 8; k++) m_seg[k] = 8'h3F;
      m_pos = 0; m_remaining = 0; m_busy = 1'b0;
    end else begin
      idx = (m_pos / SCAN_DIV) % 4;
      e_sel   = 8'((1 << (idx + 4)) | (1 << idx));
      e_left  = m_seg[idx + 4];
      e_right = m_seg[idx];
      m_pos++;
      if (s_wr && !s_dec) begin
        for (int k = 0; k < 8; k++) m_seg[k] = glyph_tab[(s_data >> (4*k)) & 32'hF];
        m_remaining = 0; m_busy = 1'b0;
      end else if (s_wr && s_data > 32'd99_999_999) begin
        m_seg[0] = 8'h79;
        for (int k = 1; k < 8; k++) m_seg[k] = 8'h00;
        m_remaining = 0; m_busy = 1'b0;
      end else if (s_wr) begin
        m_pending = s_data; m_remaining = 27; m_busy = 1'b1;
      end else if (m_remaining > 0) begin
        m_remaining--;
        if (m_remaining == 0) begin
          model_commit_dec(m_pending);
          m_busy = 1'b0;
        end
      end
    end
    #1;
    chk("tubSel", {24'd0, tubSel}, {24'd0, e_sel});
    chk("tubLeft", {24'd0, tubLeft}, {24'd0, e_left});
    chk("tubRight", {24'd0, tubRight}, {24'd0, e_right});
    chk("busy", {31'd0, busy}, {31'd0, m_busy});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 32'd0, 1'b0);
  endtask

  // Stimulus
  initial begin
    logic [31:0] d;
    int sel;
    n_tests = 0; n_fail = 0;
    glyph_tab[0] = 8'h3F; glyph_tab[1] = 8'h06; glyph_tab[2] = 8'h5B; glyph_tab[3] = 8'h4F;
    glyph_tab[4] = 8'h66; glyph_tab[5] = 8'h6D; glyph_tab[6] = 8'h7D; glyph_tab[7] = 8'h07;
    glyph_tab[8] = 8'h7F; glyph_tab[9] = 8'h6F; glyph_tab[10] = 8'h77; glyph_tab[11] = 8'h7C;
    glyph_tab[12] = 8'h39; glyph_tab[13] = 8'h5E; glyph_tab[14] = 8'h79; glyph_tab[15] = 8'h71;
    m_pos = 0; m_remaining = 0; m_busy = 1'b0; m_pending = '0;
    for (int k = 0; k < 8; k++) m_seg[k] = 8'h3F;
    rst = 1'b1; wr_en = 1'b0; wr_data = '0; dec_mode = 1'b0;

    // Reset, and a write ignored while reset is held
    step(1'b1, 1'b0, 32'd0, 1'b0);
    step(1'b1, 1'b1, 32'hFFFF_FFFF, 1'b0);
    // Idle scan: the enables walk 11, 22, 44, 88, 11 with every segment showing 3F
    idle(20);
    // Hex write
    step(1'b0, 1'b1, 32'h1234ABCD, 1'b0);
    idle(20);
    // Decimal 305
    step(1'b0, 1'b1, 32'd305, 1'b1);
    idle(40);
    // Decimal zero: digit 0 still shows 0
    step(1'b0, 1'b1, 32'd0, 1'b1);
    idle(32);
    // Overflow
    step(1'b0, 1'b1, 32'd100_000_000, 1'b1);
    idle(10);
    // Largest decimal value, then a restart at cycle 10 with 7
    step(1'b0, 1'b1, 32'd99_999_999, 1'b1);
    idle(9);
    step(1'b0, 1'b1, 32'd7, 1'b1);
    idle(35);
    // Largest decimal value run to completion
    step(1'b0, 1'b1, 32'd99_999_999, 1'b1);
    idle(32);
    // Abort by a hex write
    step(1'b0, 1'b1, 32'd99_999_999, 1'b1);
    idle(9);
    step(1'b0, 1'b1, 32'hDEAD_0F00, 1'b0);
    idle(10);
    // Reset mid-conversion
    step(1'b0, 1'b1, 32'd12_345_678, 1'b1);
    idle(4);
    step(1'b1, 1'b0, 32'd0, 1'b0);
    idle(35);
    // Random traffic
    for (int i = 0; i < 1500; i++) begin
      sel = $urandom_range(0, 3);
      case (sel)
        0: d = $urandom;
        1: d = $urandom_range(0, 999);
        2: d = $urandom_range(0, 99_999_999);
        default: d = ($urandom_range(0, 1) == 0) ? 32'd99_999_999 : 32'd100_000_000;
      endcase
      step(($urandom_range(0, 299) == 0), ($urandom_range(0, 39) == 0), d, $urandom_range(0, 1) == 1);
    end
    idle(30);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
